sync_fifo_ctl: RTL and testbench
================================

# sync_fifo_ctl

Single-clock, parametrised FIFO with occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It is the same-clock-domain successor to our dual-clock FIFO: it serves buffers where producer and consumer share one clock and need watermark-based flow control rather than only hard full/empty. Read mode is registered by default, with first-word fall-through selectable at compile time.

## Interface
- DATA_WIDTH, 32: word width in bits.
- ADDR_WIDTH, 4: DEPTH = 2**ADDR_WIDTH words (default 16); legal range 2..12.
- AFULL_TH, 12: almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 4: almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  synchronous flush; empties the FIFO and clears sticky flags.
- winc  in  1  write request.
- wdata  in  DATA_WIDTH  write data.
- wfull  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_TH.
- rinc  in  1  read request.
- rdata  out  DATA_WIDTH  read data.
- rempty  out  1  count == 0.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while wfull.
- underflow  out  1  sticky; a read was attempted while rempty.

## Operation
- Storage: DEPTH x DATA_WIDTH array; wptr/rptr are ADDR_WIDTH bits and wrap naturally at DEPTH-1 -> 0. The array is not reset.
- Accepted write: we = winc && !wfull. Accepted read: re = rinc && !rempty. Both are evaluated against the flags registered at the current edge. There is no bypass: a write while full is dropped even if rinc is high, and a read while empty is refused even if winc is high.
- count_next = count + we - re; both accepted gives an unchanged count, and both pointers advance.
- All flags are registered and computed from count_next, so they are coherent with count in the same cycle.
- overflow is set on winc && wfull; underflow is set on rinc && rempty. Both stay set until rst_n or clr.
- Priority: rst_n low > clr > normal operation.
- rst_n low or clr high at an edge:
  - wptr = rptr = count = 0; rempty = 1; wfull = 0; almost_empty = 1; almost_full = 0; overflow = underflow = 0.
  - rdata = 0 on reset only; clr leaves rdata unchanged.
  - winc/rinc in the same cycle are ignored and do not set the sticky flags.

## Timing
- Write accepted at edge N: count increments and rempty falls after edge N.
- Default registered read: re at edge N loads mem[rptr] into rdata after edge N (one-cycle read latency). rdata holds its value when no read is accepted.
- Full boundary: the DEPTH-th accepted write at edge N raises wfull after edge N. The first write attempt at edge N+1 is dropped and sets overflow.
- Empty boundary: the last accepted read at edge N raises rempty after edge N. Its data is valid on rdata after edge N.
- Wrap: pointers wrap without a bubble; the FIFO sustains one write and one read per cycle indefinitely at any occupancy between 1 and DEPTH-1.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word fall-through mode.
  - rdata = mem[rptr] combinationally whenever rempty is 0; rinc pops the word.
  - A word written at edge N is visible on rdata after edge N, together with rempty falling.
  - rdata is undefined (don't-care) while rempty = 1.
- SYNC_FIFO_FWFT_EN undefined: registered read mode as described under Timing.
- All other behaviour is identical in both modes.

## Test plan
- Reset: hold rst_n low 2 cycles with winc = rinc = 1 -> count = 0, rempty = 1, almost_empty = 1, wfull = 0, overflow = underflow = 0, rdata = 0.
- Fill: 17 writes (wdata 0..16), rinc = 0 -> almost_full rises when count reaches 12; wfull rises after the 16th write; the 17th write (data 16) is dropped and overflow = 1. Draining then returns 0..15 in order, rempty rises after the 16th read, and a further rinc sets underflow = 1.
- Streaming wrap: preload 3 words, then 40 cycles of simultaneous winc/rinc with an incrementing pattern -> count stays 3, the output sequence is contiguous with no loss or duplication, and the pointers wrap twice.
- Threshold edges: AFULL_TH = 12, AEMPTY_TH = 4 -> almost_empty = 1 at count 4 and 0 at count 5; almost_full = 0 at count 11 and 1 at count 12.
- Flush mid-operation: at count 9 with overflow set, assert clr together with winc/rinc -> next cycle count = 0, rempty = 1, overflow = 0. The next write of 0xA5 reads back 0xA5.
- FWFT build (SYNC_FIFO_FWFT_EN): write 0x11 at edge N -> after edge N, rdata = 0x11 with rempty = 0; rinc at edge N+1 -> rempty = 1 after edge N+1.

Source files
------------

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty watermarks, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through reads; the default is a registered read port.
module sync_fifo_ctl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  almost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  we;
  logic                  re;
  logic                  flush;

  // Requests are qualified only by the registered flags: no full/empty bypass.
  assign we    = winc && !wfull;
  assign re    = rinc && !rempty;
  assign flush = !rst_n || clr;

  always_comb begin
    count_next = count + (ADDR_WIDTH+1)'(we) - (ADDR_WIDTH+1)'(re);
  end

  // Storage is not reset; writes during reset or flush are discarded.
  always_ff @(posedge clk) begin
    if (!flush && we) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rempty       <= 1'b1;
      wfull        <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      count        <= count_next;
      // Flags derive from count_next so they stay coherent with count.
      rempty       <= (count_next == '0);
      wfull        <= (count_next == DEPTH_C);
      almost_empty <= (count_next <= AEMPTY_C);
      almost_full  <= (count_next >= AFULL_C);
      overflow     <= overflow  || (winc && wfull);
      underflow    <= underflow || (rinc && rempty);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; don't-care while empty.
  assign rdata = mem[rptr];
`else
  // One-cycle read latency; flush leaves the last read word in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (!clr && re) begin
      rdata <= mem[rptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Directed self-checking bench for sync_fifo_ctl (default parameters; follows SYNC_FIFO_FWFT_EN for read timing).
module tb_sync_fifo_ctl;

  logic        clk = 1'b0;
  logic        rst_n, clr, winc, rinc;
  logic [31:0] wdata;
  logic        wfull, almost_full, rempty, almost_empty, overflow, underflow;
  logic [31:0] rdata;
  logic [4:0]  count;

  int vectors = 0;
  int miscompares = 0;

  sync_fifo_ctl dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .winc(winc), .wdata(wdata), .wfull(wfull), .almost_full(almost_full),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    winc  = w;
    rinc  = r;
    wdata = d;
    @(posedge clk);
    #1;
    winc = 1'b0;
    rinc = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check(tag, rdata, exp);
    step(1'b0, 1'b1, 32'h0);
`else
    step(1'b0, 1'b1, 32'h0);
    check(tag, rdata, exp);
`endif
  endtask

  task automatic stream_check(input string tag, input logic [31:0] wd, input logic [31:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check(tag, rdata, exp);
    step(1'b1, 1'b1, wd);
`else
    step(1'b1, 1'b1, wd);
    check(tag, rdata, exp);
`endif
  endtask

  initial begin
    int n;
    rst_n = 1'b0; clr = 1'b0; winc = 1'b0; rinc = 1'b0; wdata = '0;
    #1;

    // Reset with both requests active
    step(1'b1, 1'b1, 32'hDEAD);
    step(1'b1, 1'b1, 32'hBEEF);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rempty", 32'(rempty), 32'd1);
    check("rst_aempty", 32'(almost_empty), 32'd1);
    check("rst_wfull", 32'(wfull), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("rst_rdata", rdata, 32'd0);
`endif
    rst_n = 1'b1;

    // Fill with 17 writes; the 17th is dropped
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 32'(i));
      n = (i + 1 > 16) ? 16 : i + 1;
      check("fill_count", 32'(count), 32'(n));
      check("fill_aempty", 32'(almost_empty), 32'(n <= 4));
      check("fill_afull", 32'(almost_full), 32'(n >= 12));
      check("fill_wfull", 32'(wfull), 32'(n == 16));
      check("fill_ovf", 32'(overflow), 32'(i == 16));
      check("fill_rempty", 32'(rempty), 32'd0);
    end

    // Drain 0..15 in order
    for (int i = 0; i < 16; i++) begin
      pop_check("drain_data", 32'(i));
      check("drain_count", 32'(count), 32'(15 - i));
      check("drain_rempty", 32'(rempty), 32'(i == 15));
      check("drain_afull", 32'(almost_full), 32'(15 - i >= 12));
      check("drain_aempty", 32'(almost_empty), 32'(15 - i <= 4));
    end
    check("drain_unf", 32'(underflow), 32'd0);
    step(1'b0, 1'b1, 32'h0);
    check("empty_unf", 32'(underflow), 32'd1);
    check("empty_count", 32'(count), 32'd0);

    // Flush clears the sticky flag
    clr = 1'b1;
    step(1'b0, 1'b0, 32'h0);
    clr = 1'b0;
    check("clr_unf", 32'(underflow), 32'd0);

    // Streaming: preload 3, then 40 simultaneous write/read cycles
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'(100 + i));
    check("pre_count", 32'(count), 32'd3);
    for (int k = 0; k < 40; k++) begin
      stream_check("stream_data", 32'(103 + k), 32'(100 + k));
      check("stream_count", 32'(count), 32'd3);
    end

    // Contents now 140..142; fill to full, attempt one more write
    for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 32'(143 + i));
    check("refill_wfull", 32'(wfull), 32'd1);
    step(1'b1, 1'b1, 32'd999);
    check("full_wr_rd_count", 32'(count), 32'd15);
    check("full_wr_rd_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i < 7; i++) pop_check("pre_flush_data", 32'(140 + i));
    check("pre_flush_count", 32'(count), 32'd9);
    check("pre_flush_ovf", 32'(overflow), 32'd1);

    // Flush with both requests active
    clr = 1'b1;
    step(1'b1, 1'b1, 32'h77);
    clr = 1'b0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_rempty", 32'(rempty), 32'd1);
    check("flush_ovf", 32'(overflow), 32'd0);
    check("flush_unf", 32'(underflow), 32'd0);
    check("flush_aempty", 32'(almost_empty), 32'd1);
    check("flush_afull", 32'(almost_full), 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    check("flush_rdata_hold", rdata, 32'd146);
`endif
    step(1'b1, 1'b0, 32'hA5);
    check("a5_count", 32'(count), 32'd1);
    check("a5_rempty", 32'(rempty), 32'd0);
    pop_check("a5_data", 32'hA5);
    check("a5_rempty_after", 32'(rempty), 32'd1);

    // Write and read on empty: read refused, write accepted
    step(1'b1, 1'b1, 32'h5A);
    check("empty_wr_rd_count", 32'(count), 32'd1);
    check("empty_wr_rd_unf", 32'(underflow), 32'd1);
    pop_check("empty_wr_rd_data", 32'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
